uart_transmitter: RTL and testbench

Serial UART transmitter for the Bluetooth link. It drives the Bluetooth module's BT_RX pin with 8N1 frames: one start bit, 8 data bits LSB-first, no parity, and STOP_BITS stop bits. Bytes from the core logic enter through a valid/ready handshake into a small FIFO, so short bursts can be queued. It is the outbound counterpart of the UART receive path and shares its board clock domain.

---
 rtl/uart_transmitter.sv | 168 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter for the Bluetooth link (drives BT_RX).
// Bytes enter through a valid/ready handshake into a small FIFO and are sent
// LSB-first with one start bit and STOP_BITS stop bits.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   tx_data    byte to send, taken when tx_valid && tx_ready
//   tx_valid   producer has a byte
//   tx_ready   FIFO not full (registered)
//   tx         serial line, idle high (registered)
//   busy       frame in progress or bytes queued
//   tx_done    one-cycle pulse during the final stop-bit cycle on tx
//   fifo_count bytes queued, excluding the byte in flight
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic            stop_cnt;
    logic [7:0]      sh;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr_n;
    logic [PW-1:0]   rptr_n;

    logic            empty;
    logic            push;
    logic            pop;
    logic            bit_end;
    logic            frame_end;
    logic            full_n;

    assign empty      = (wptr == rptr);
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (cnt == LAST);
    assign frame_end  = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
    // Pop from IDLE, or at the last stop cycle for back-to-back frames
    assign pop        = !empty && ((state == IDLE) || frame_end);
    assign wptr_n     = wptr + PW'(push);
    assign rptr_n     = rptr + PW'(pop);
    assign full_n     = (wptr_n[AW] != rptr_n[AW]) &&
                        (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
    assign fifo_count = wptr - rptr;
    assign busy       = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= tx_data;
        end
    end

    // tx_ready looks ahead at next-cycle pointers so it stays registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            tx_ready <= 1'b1;
        end else begin
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            tx_ready <= !full_n;
        end
    end

    // tx and tx_done are registered from the current state, so the line
    // lags the FSM by one cycle and tx_done lines up with the last stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            sh       <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        sh       <= mem[rptr[AW-1:0]];
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= sh[0];
                    if (bit_end) begin
                        cnt     <= '0;
                        sh      <= sh >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            tx_done <= 1'b1;
                            if (pop) begin
                                sh       <= mem[rptr[AW-1:0]];
                                bit_idx  <= '0;
                                stop_cnt <= 1'b0;
                                state    <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench for uart_transmitter.
// dut_a: 4 clocks/bit, 1 stop bit; dut_b: 1 clock/bit, 2 stop bits.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;
    logic [2:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(4),
        .STOP_BITS(1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .tx_data(data_a),
        .tx_valid(valid_a),
        .tx_ready(ready_a),
        .tx(tx_a),
        .busy(busy_a),
        .tx_done(done_a),
        .fifo_count(cnt_a)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(1),
        .FIFO_DEPTH(4),
        .STOP_BITS(2)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .tx_data(data_b),
        .tx_valid(valid_b),
        .tx_ready(ready_b),
        .tx(tx_b),
        .busy(busy_b),
        .tx_done(done_b),
        .fifo_count(cnt_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_fall(input bit sel, output int n);
        n = 0;
        while (((sel ? tx_b : tx_a) !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("fall_timeout", int'(n < 500), 1);
    endtask

    task automatic write_a(input logic [7:0] b);
        data_a  = b;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic frame_a(input logic [7:0] b, input string tag);
        int   bad = 0;
        int   dn = 0;
        int   at = -1;
        int   k;
        logic e;
        for (int i = 0; i < 40; i++) begin
            k = i / 4;
            if (k == 0) e = 1'b0;
            else if (k == 9) e = 1'b1;
            else e = b[k-1];
            if (tx_a !== e) bad++;
            if (done_a === 1'b1) begin
                dn++;
                at = i;
            end
            @(negedge clk);
        end
        chk({tag, "_bits"}, bad, 0);
        chk({tag, "_done_n"}, dn, 1);
        chk({tag, "_done_at"}, at, 39);
    endtask

    task automatic frames(input int n, input int base, input int step,
                          input string tag);
        int f;
        wait_fall(1'b0, f);
        for (int k = 0; k < n; k++) begin
            frame_a(8'(base + k * step), $sformatf("%s_f%0d", tag, k));
        end
    endtask

    task automatic stream(input int n, input int base, input int step,
                          output int stalls, output int first_cnt,
                          output int maxc);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        stalls    = 0;
        first_cnt = -1;
        maxc      = 0;
        data_a    = 8'(base);
        valid_a   = 1'b1;
        while (idx < n && cyc < 2000) begin
            acc = ready_a;
            if (!acc) begin
                if (stalls == 0) first_cnt = int'(cnt_a);
                stalls++;
            end
            if (int'(cnt_a) > maxc) maxc = int'(cnt_a);
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                data_a = 8'(base + idx * step);
            end
        end
        valid_a = 1'b0;
        chk("stream_accepted", idx, n);
    endtask

    initial begin
        int n, stalls, first_cnt, maxc, bad, dn, at;

        rst     = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_tx", int'(tx_a), 1);
        chk("rst_ready", int'(ready_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_count", int'(cnt_a), 0);
        rst = 1'b1;
        @(negedge clk);

        // single byte 0x55 on an idle line
        write_a(8'h55);
        chk("t1_count", int'(cnt_a), 1);
        chk("t1_busy", int'(busy_a), 1);
        wait_fall(1'b0, n);
        chk("t1_latency", n, 2);
        frame_a(8'h55, "t1");
        chk("t1_idle_tx", int'(tx_a), 1);
        chk("t1_idle_busy", int'(busy_a), 0);

        // two bytes on consecutive cycles, contiguous frames
        data_a  = 8'hA3;
        valid_a = 1'b1;
        @(negedge clk);
        data_a  = 8'h0F;
        @(negedge clk);
        valid_a = 1'b0;
        data_a  = 8'hEE;
        wait_fall(1'b0, n);
        frame_a(8'hA3, "t2a");
        frame_a(8'h0F, "t2b");
        chk("t2_idle_busy", int'(busy_a), 0);

        // six writes, FIFO fills and the sixth stalls
        fork
            stream(6, 8'h11, 8'h11, stalls, first_cnt, maxc);
            frames(6, 8'h11, 8'h11, "t3");
        join
        chk("t3_full_count", first_cnt, 4);
        chk("t3_stalls", stalls, 37);
        chk("t3_idle_busy", int'(busy_a), 0);

        // reset mid-frame with two bytes queued
        data_a  = 8'h00;
        valid_a = 1'b1;
        @(negedge clk);
        data_a  = 8'h01;
        @(negedge clk);
        data_a  = 8'h02;
        @(negedge clk);
        valid_a = 1'b0;
        wait_fall(1'b0, n);
        repeat (16) @(negedge clk);
        chk("t4_pre_tx", int'(tx_a), 0);
        chk("t4_pre_count", int'(cnt_a), 2);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_tx", int'(tx_a), 1);
        chk("t4_rst_count", int'(cnt_a), 0);
        chk("t4_rst_busy", int'(busy_a), 0);
        chk("t4_rst_ready", int'(ready_a), 1);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        chk("t4_quiet", bad, 0);
        write_a(8'h3C);
        wait_fall(1'b0, n);
        chk("t4_new_latency", n, 2);
        frame_a(8'h3C, "t4");

        // one clock per bit, two stop bits
        data_b  = 8'hFF;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        wait_fall(1'b1, n);
        chk("t5_latency", n, 2);
        bad = 0;
        dn  = 0;
        at  = -1;
        for (int i = 0; i < 12; i++) begin
            if (tx_b !== ((i == 0) ? 1'b0 : 1'b1)) bad++;
            if (done_b === 1'b1) begin
                dn++;
                at = i;
            end
            @(negedge clk);
        end
        chk("t5_bits", bad, 0);
        chk("t5_done_n", dn, 1);
        chk("t5_done_at", at, 10);
        chk("t5_idle_busy", int'(busy_b), 0);

        // twelve bytes streamed, pointers wrap
        fork
            stream(12, 0, 1, stalls, first_cnt, maxc);
            frames(12, 0, 1, "t6");
        join
        chk("t6_max_count", maxc, 4);
        chk("t6_idle_busy", int'(busy_a), 0);
        chk("t6_idle_count", int'(cnt_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
